mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-ported memory between the instruction-fetch stage and the data-memory (MEM) stage of the 5-stage MiniMIPS pipeline.
- A three-state FSM grants the port, registers each access, and returns read data to the requester.
- Drives `stall_if` and `stall_mem`, which the hazard logic ORs into StallF, StallD and the pipeline-register enables.
- Data accesses have priority. A stuck memory is caught by a wait-cycle watchdog.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 15, cycles allowed with `mem_ready` low before an access is force-completed

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `if_req`  in  1  fetch wants the instruction at `if_addr`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  fetched instruction, held while `if_valid`
- `if_valid`  out  1  `if_rdata` is valid and not yet consumed
- `dm_read`  in  1  MemReadM
- `dm_write`  in  1  MemWriteM
- `dm_addr`  in  ADDR_W  ALUOutM
- `dm_wdata`  in  DATA_W  WriteDataM
- `dm_rdata`  out  DATA_W  load data, valid while `dm_done`
- `dm_done`  out  1  one-cycle pulse: the data access is complete
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  write enable
- `mem_addr`  out  ADDR_W  access address
- `mem_wdata`  out  DATA_W  write data
- `mem_ready`  in  1  memory completes the access this cycle
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`
- `stall_if`  out  1  hold the PC / fetch stage
- `stall_mem`  out  1  freeze all pipeline registers (F, D, E, M)
- `timeout_err`  out  1  sticky watchdog flag

## Operation
States: `IDLE`, `FETCH`, `DATA`.

Transitions:
- From `IDLE`, a data grant is taken when `(dm_read|dm_write) & ~dm_done`. It goes to `DATA` and latches `dm_addr`, `dm_wdata` and `mem_we=dm_write`.
- Otherwise, a fetch grant is taken when `if_req & ~if_valid`. It goes to `FETCH` and latches `if_addr` with `mem_we=0`.
- Data always beats fetch when both are pending in `IDLE`. An access already in `FETCH` is never pre-empted.
- In `FETCH`/`DATA`, `mem_req` = 1 and address, write data and `mem_we` come from the latches. They are stable for the whole access.
- `FETCH` with `mem_ready`: `if_rdata <= mem_rdata`, `if_valid <= 1`, go to `IDLE`.
- `DATA` with `mem_ready`: on a read, `dm_rdata <= mem_rdata`; on a write, `dm_rdata` is unchanged. Then `dm_done <= 1` for exactly one cycle and go to `IDLE`.

Fetch buffer:
- `if_valid` clears on any clock edge where `if_valid & ~stall_mem`, i.e. the pipeline advanced and consumed the instruction.
- If a fetch completes while `stall_mem` is high, the instruction is held until the stall releases. It is never lost.

Stalls (combinational):
- `stall_mem = (dm_read|dm_write) & ~dm_done`
- `stall_if = if_req & ~if_valid`

Watchdog:
- `wait_cnt` (width `$clog2(MAX_WAIT+1)`) clears on each grant.
- It increments each cycle in `FETCH`/`DATA` while `mem_ready` = 0.
- When `wait_cnt == MAX_WAIT` with `mem_ready` still low, the access completes as if `mem_ready` were high with read data forced to 0, and `timeout_err <= 1`.
- `timeout_err` clears only on reset.

## Timing
- Reset (async, on `rst_n` low): state `IDLE`; `mem_req`, `mem_we`, `if_valid`, `dm_done`, `timeout_err`, `wait_cnt` = 0; `if_rdata`, `dm_rdata`, `mem_addr`, `mem_wdata` = 0.
- Asserting `rst_n` low mid-access drops `mem_req` immediately, with no clock needed. The in-flight access is abandoned.
- Minimum latency is 2 cycles. Example: grant in `IDLE` at cycle t, `mem_req` high at t+1, `mem_ready` at t+1, then `if_valid`/`dm_done` at t+2.
- Each wait cycle adds 1. An access is force-completed with `timeout_err` set at t+2+`MAX_WAIT` at the latest.
- In the `dm_done` cycle, `stall_mem` = 0, so the M/W register captures `dm_rdata` on that edge.
- `IDLE` during `dm_done` never re-grants the same data request. A fetch may be granted in that cycle.
- `mem_req` is decoded from the state register only. There is no combinational path from any requester input to `mem_*`.
- The port is occupied back-to-back: at most one access is in flight, and `IDLE` lasts at least 1 cycle between accesses.

## Test plan
- Reset mid-`DATA` with `mem_ready` held low: `mem_req` falls the same cycle. After release, all outputs are 0 and the state is `IDLE`.
- `if_req`=1, `if_addr`=0x40, `mem_ready`=1 every cycle, `mem_rdata`=0x2002000A: `mem_addr`=0x40 at t+1, `if_valid`=1 with `if_rdata`=0x2002000A at t+2, `stall_if` low at t+2.
- `if_req` and `dm_read` (`dm_addr`=0x100) both high in `IDLE`: `DATA` is granted first with `mem_addr`=0x100. `FETCH` follows after `dm_done`. `stall_mem` is high until the `dm_done` cycle.
- Fetch in progress, then `dm_write` (`dm_addr`=0x200, `dm_wdata`=0xDEADBEEF) arrives with `mem_ready` 2 cycles late: the fetch finishes first and `if_valid` holds through the data access. `mem_we`=1 with `mem_wdata`=0xDEADBEEF. `if_valid` clears only after `stall_mem` drops.
- `dm_read` with `mem_ready` stuck low: after 15 wait cycles `dm_done` pulses with `dm_rdata`=0 and `timeout_err`=1. `timeout_err` stays 1 through later good accesses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch stage and
// the data-memory (MEM) stage of the 5-stage MiniMIPS pipeline. A three-state
// FSM (IDLE / FETCH / DATA) grants the port and registers each access. It
// returns the read data to the requester and raises the stall requests that
// the hazard unit ORs into StallF, StallD and the pipeline-register enables.
// A data access has priority over a fetch. An access already in FETCH is
// never pre-empted. A wait-cycle watchdog force-completes an access to a
// memory that never answers.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request and PC
//   if_rdata/if_valid fetched instruction, held until the pipeline advances
//   dm_read/dm_write  MemReadM / MemWriteM
//   dm_addr/dm_wdata  ALUOutM / WriteDataM
//   dm_rdata/dm_done  load data and one-cycle completion pulse
//   mem_*             single-ported memory request side
//   mem_ready/rdata   memory completion and read data
//   stall_if          hold the PC / fetch stage
//   stall_mem         freeze the F, D, E and M pipeline registers
//   timeout_err       sticky watchdog flag, cleared only by reset
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              we_q,       we_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_done_q,  dm_done_d;
    logic              timeout_q,  timeout_d;

    logic              dm_pending;
    logic              if_pending;
    logic              wait_expired;
    logic              access_done;
    logic [DATA_W-1:0] rd_data;

    // A data request stays asserted during its dm_done cycle while the
    // pipeline advances. Masking with dm_done_q keeps the same load/store
    // from being granted twice.
    assign dm_pending = (dm_read | dm_write) & ~dm_done_q;
    assign if_pending = if_req & ~if_valid_q;

    assign stall_mem = dm_pending;
    assign stall_if  = if_pending;

    // The watchdog completes the access as though the memory had answered.
    // The read data is forced to zero so that no stale bus value leaks in.
    assign wait_expired = (wait_cnt_q == WAIT_LIMIT);
    assign access_done  = mem_ready | wait_expired;
    assign rd_data      = mem_ready ? mem_rdata : '0;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wait_cnt_d = wait_cnt_q;
        if_rdata_d = if_rdata_q;
        if_valid_d = if_valid_q;
        dm_rdata_d = dm_rdata_q;
        dm_done_d  = 1'b0;
        timeout_d  = timeout_q;

        // The instruction is consumed on the first edge where the pipeline
        // is not frozen. While stall_mem is high it is held.
        if (if_valid_q && !stall_mem) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (dm_pending) begin
                    state_d    = DATA;
                    addr_d     = dm_addr;
                    wdata_d    = dm_wdata;
                    we_d       = dm_write;
                    wait_cnt_d = '0;
                end else if (if_pending) begin
                    state_d    = FETCH;
                    addr_d     = if_addr;
                    we_d       = 1'b0;
                    wait_cnt_d = '0;
                end
            end

            FETCH: begin
                if (access_done) begin
                    // A fetch is granted only when if_valid_q is low, so
                    // the buffer is free here.
                    if_rdata_d = rd_data;
                    if_valid_d = 1'b1;
                    state_d    = IDLE;
                    if (!mem_ready) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (access_done) begin
                    if (!we_q) begin
                        dm_rdata_d = rd_data;
                    end
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                    if (!mem_ready) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wait_cnt_q <= '0;
            if_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_rdata_q <= '0;
            dm_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wait_cnt_q <= wait_cnt_d;
            if_rdata_q <= if_rdata_d;
            if_valid_q <= if_valid_d;
            dm_rdata_q <= dm_rdata_d;
            dm_done_q  <= dm_done_d;
            timeout_q  <= timeout_d;
        end
    end

    // The memory side is decoded from registers only. An asynchronous reset
    // forces IDLE, so mem_req drops without waiting for a clock edge.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rdata    = if_rdata_q;
    assign if_valid    = if_valid_q;
    assign dm_rdata    = dm_rdata_q;
    assign dm_done     = dm_done_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors plus
// hand-written sequences for reset, pre-emption and the watchdog.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_rd;
        logic        dm_wr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_ivld;
        logic [31:0] e_irdata;
        logic        e_done;
        logic [31:0] e_drdata;
        logic        e_sif;
        logic        e_smem;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
        dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    function automatic vec_t mk(input logic rst, input logic ir, input logic [31:0] ia,
                                input logic rd, input logic wr, input logic [31:0] da,
                                input logic [31:0] dw, input logic rdy, input logic [31:0] rdat,
                                input logic e_req, input logic e_we, input logic [31:0] e_addr,
                                input logic e_ivld, input logic [31:0] e_irdata,
                                input logic e_done, input logic [31:0] e_drdata,
                                input logic e_sif, input logic e_smem);
        vec_t v;
        v.rst = rst; v.if_req = ir; v.if_addr = ia; v.dm_rd = rd; v.dm_wr = wr;
        v.dm_addr = da; v.dm_wdata = dw; v.rdy = rdy; v.rdata = rdat;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_ivld = e_ivld;
        v.e_irdata = e_irdata; v.e_done = e_done; v.e_drdata = e_drdata;
        v.e_sif = e_sif; v.e_smem = e_smem;
        return v;
    endfunction

    initial begin
        int n;
        zero_inputs();
        rst_n = 1'b0;

        // Plain fetch, mem_ready high every cycle: 2-cycle latency.
        vecs[0] = mk(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h2002000A,
                     0, 0, 32'h0,  0, 32'h0,        0, 32'h0, 1, 0);
        vecs[1] = mk(0, 1, 32'h40, 0, 0, 0, 0, 1, 32'h2002000A,
                     1, 0, 32'h40, 0, 32'h0,        0, 32'h0, 1, 0);
        vecs[2] = mk(0, 1, 32'h44, 0, 0, 0, 0, 1, 32'h2002000A,
                     0, 0, 32'h40, 1, 32'h2002000A, 0, 32'h0, 0, 0);
        vecs[3] = mk(0, 0, 32'h44, 0, 0, 0, 0, 1, 32'h2002000A,
                     0, 0, 32'h40, 0, 32'h2002000A, 0, 32'h0, 0, 0);
        // Fetch and load both pending in IDLE: data goes first.
        vecs[4] = mk(1, 1, 32'h80, 1, 0, 32'h100, 0, 0, 32'h11111111,
                     0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        1, 1);
        vecs[5] = mk(0, 1, 32'h80, 1, 0, 32'h100, 0, 1, 32'hCAFEF00D,
                     1, 0, 32'h100, 0, 32'h0,        0, 32'h0,        1, 1);
        vecs[6] = mk(0, 1, 32'h80, 1, 0, 32'h100, 0, 1, 32'h2002000A,
                     0, 0, 32'h100, 0, 32'h0,        1, 32'hCAFEF00D, 1, 0);
        vecs[7] = mk(0, 1, 32'h80, 0, 0, 32'h0,   0, 1, 32'h8C000000,
                     1, 0, 32'h80,  0, 32'h0,        0, 32'hCAFEF00D, 1, 0);
        vecs[8] = mk(0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,
                     0, 0, 32'h80,  1, 32'h8C000000, 0, 32'hCAFEF00D, 0, 0);
        vecs[9] = mk(0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,
                     0, 0, 32'h80,  0, 32'h8C000000, 0, 32'hCAFEF00D, 0, 0);

        // Reset state.
        do_reset();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_dm_done", 32'(dm_done), 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);

        // Reset mid-DATA with mem_ready low: mem_req drops with no clock.
        dm_read = 1; dm_addr = 32'h1F0;
        step();
        chk("mid_rst_req_before", 32'(mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_async", 32'(mem_req), 32'h0);
        zero_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_req", 32'(mem_req), 32'h0);
        chk("post_rst_we", 32'(mem_we), 32'h0);
        chk("post_rst_addr", mem_addr, 32'h0);
        chk("post_rst_dm_rdata", dm_rdata, 32'h0);
        chk("post_rst_stalls", {30'h0, stall_if, stall_mem}, 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) do_reset();
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_read = vecs[i].dm_rd; dm_write = vecs[i].dm_wr;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].e_ivld));
            chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_irdata);
            chk($sformatf("v%0d_dm_done", i), 32'(dm_done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].e_drdata);
            chk($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(vecs[i].e_sif));
            chk($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].e_smem));
            step();
        end

        // Fetch in progress, then a store arrives; store ready 2 cycles late.
        do_reset();
        if_req = 1; if_addr = 32'h40;
        #1; step();
        dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        #1;
        chk("pre_fetch_kept", mem_addr, 32'h40);
        chk("pre_fetch_we", 32'(mem_we), 32'h0);
        chk("pre_stall_mem", 32'(stall_mem), 32'h1);
        step();
        chk("pre_fetch_wait", mem_addr, 32'h40);
        mem_ready = 1; mem_rdata = 32'h12345678;
        #1; step();
        mem_ready = 0;
        #1;
        chk("pre_if_valid", 32'(if_valid), 32'h1);
        chk("pre_if_rdata", if_rdata, 32'h12345678);
        chk("pre_idle_gap", 32'(mem_req), 32'h0);
        step();
        chk("st_mem_we", 32'(mem_we), 32'h1);
        chk("st_mem_addr", mem_addr, 32'h200);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_if_valid_held", 32'(if_valid), 32'h1);
        step();
        chk("st_wait2_if_valid", 32'(if_valid), 32'h1);
        mem_ready = 1;
        #1; step();
        mem_ready = 0; if_req = 0;
        #1;
        chk("st_dm_done", 32'(dm_done), 32'h1);
        chk("st_stall_mem_low", 32'(stall_mem), 32'h0);
        chk("st_if_valid_done", 32'(if_valid), 32'h1);
        chk("st_dm_rdata_kept", dm_rdata, 32'h0);
        step();
        dm_write = 0;
        #1;
        chk("st_if_valid_clr", 32'(if_valid), 32'h0);
        chk("st_done_pulse", 32'(dm_done), 32'h0);

        // Watchdog: load with mem_ready stuck low.
        do_reset();
        dm_read = 1; dm_addr = 32'h300; mem_rdata = 32'hFFFFFFFF;
        #1; step();
        n = 1;
        while (!dm_done && n < 40) begin
            chk("wd_req_held", 32'(mem_req), 32'h1);
            chk("wd_no_err_yet", 32'(timeout_err), 32'h0);
            step();
            n++;
        end
        chk("wd_latency", 32'(n), 32'd17);
        chk("wd_dm_done", 32'(dm_done), 32'h1);
        chk("wd_dm_rdata", dm_rdata, 32'h0);
        chk("wd_timeout_err", 32'(timeout_err), 32'h1);
        dm_read = 0;
        #1; step();
        chk("wd_done_pulse", 32'(dm_done), 32'h0);
        dm_read = 1; dm_addr = 32'h304; mem_ready = 1; mem_rdata = 32'h55AA55AA;
        #1; step();
        step();
        chk("wd_good_done", 32'(dm_done), 32'h1);
        chk("wd_good_rdata", dm_rdata, 32'h55AA55AA);
        chk("wd_err_sticky", 32'(timeout_err), 32'h1);
        dm_read = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
